instr_fetch_unit: RTL

//  Reader side of the instruction memory. Holds the PC, drives the byte address

---
 rtl/instr_fetch_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational IM and
// registers the returned word into the IF/ID pipeline register.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] Instr_addr,
  input  logic [31:0] Instruction,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic        fetch_done_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] count_q, count_d;
  logic        in_range;

  assign in_range = (pc_q <= LAST_PC) && (pc_q[1:0] == 2'b00);

  // NOTE: every signal written here gets a default first, so no path through
  // the priority chain can leave one unassigned and infer a latch.
  always_comb begin
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    count_d    = count_q;

    if (redirect_i) begin
      // A redirect wins outright; stall and flush are ignored this cycle.
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      id_valid_d = 1'b0;
    end else if (flush_i) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP;
      if (!stall_i && in_range) pc_d = pc_q + 32'd4;
    end else if (stall_i) begin
      // Everything holds.
    end else if (in_range) begin
      id_valid_d = 1'b1;
      id_instr_d = Instruction;
      id_pc_d    = pc_q;
      id_pc4_d   = pc_q + 32'd4;
      pc_d       = pc_q + 32'd4;
      count_d    = count_q + 32'd1;
    end else begin
      // Out of range: never capture IM data; PC stays put until redirected.
      id_valid_d = 1'b0;
      id_instr_d = NOP;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP;
      id_pc_q    <= 32'd0;
      id_pc4_q   <= 32'd4;
      count_q    <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      count_q    <= count_d;
    end
  end

  assign Instr_addr    = pc_q;
  assign fetch_done_o  = !in_range;
  assign id_valid_o    = id_valid_q;
  assign id_instr_o    = id_instr_q;
  assign id_pc_o       = id_pc_q;
  assign id_pc4_o      = id_pc4_q;
  assign fetch_count_o = count_q;

endmodule
